// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI response/command framing path: frame geometry,
// fill byte, instruction codes and the serializer state encoding.
package spi_frame_pkg;

  localparam int unsigned FRAME_DATA_BYTES = 8;
  localparam logic [7:0]  FRAME_FILL_BYTE  = 8'hFF;

  localparam logic [7:0] INSTR_MIN = 8'h00;
  localparam logic [7:0] INSTR_MAX = 8'h0B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_CSUM   = 2'd3
  } frame_state_e;

  function automatic logic is_read_instr(input logic [7:0] instr);
    return instr inside {8'h00, 8'h04};
  endfunction

  function automatic logic is_camwrite_instr(input logic [7:0] instr);
    return instr inside {8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0B};
  endfunction

  function automatic logic is_mem_instr(input logic [7:0] instr);
    return instr inside {[8'h07:8'h0A]};
  endfunction

  function automatic logic is_known_instr(input logic [7:0] instr);
    return (instr >= INSTR_MIN) && (instr <= INSTR_MAX);
  endfunction

endpackage

// File: rtl/frame_checksum_xor.sv
// Running XOR accumulator for frame checksums; clear beats seed beats update.
// Shared by the transmit serializer and the receive-side checksum check.
module frame_checksum_xor (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       seed_i,
  input  logic [7:0] seed_byte_i,
  input  logic       update_i,
  input  logic [7:0] update_byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = 8'h00;
    end else if (seed_i) begin
      sum_d = seed_byte_i;
    end else if (update_i) begin
      sum_d = sum_q ^ update_byte_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/resp_frame_serializer.sv
// Streams one response frame (instr header, payload MSB-first, XOR checksum)
// to the SPI slave shifter, one byte per tx_req, with a one-cycle registered reply.
module resp_frame_serializer
  import spi_frame_pkg::*;
#(
  parameter int unsigned DATA_BYTES = FRAME_DATA_BYTES,
  parameter logic [7:0]  FILL_BYTE  = FRAME_FILL_BYTE
) (
  input  logic                    sysClk,
  input  logic                    sysRst_n,
  input  logic [7:0]              resp_instr,
  input  logic [8*DATA_BYTES-1:0] resp_data,
  input  logic                    resp_valid,
  output logic                    resp_ready,
  input  logic                    cs_active,
  input  logic                    tx_req,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid,
  output logic                    busy,
  output logic                    underrun,
  output logic                    frame_done,
  output logic                    frame_abort,
  output frame_state_e            dbg_state
);

  localparam int unsigned PW       = 8 * DATA_BYTES;
  localparam logic [3:0]  LAST_IDX = 4'(DATA_BYTES - 1);

  // Handshake: a frame transfers on any rising edge where resp_valid and
  // resp_ready are both high; the handler may hold resp_valid and its data
  // across cycles, and resp_ready is registered so it is low during reset.
  frame_state_e    state_q, state_d;
  logic [7:0]      instr_q, instr_d;
  logic [PW-1:0]   data_q, data_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_valid_q, tx_valid_d;
  logic            underrun_q, underrun_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;

  logic            accept;
  logic            cks_clear, cks_seed, cks_update;
  logic [7:0]      cks_sum;
  logic [7:0]      top_byte;

  assign top_byte = data_q[PW-1 -: 8];

  frame_checksum_xor u_checksum (
    .clk_i        (sysClk),
    .rst_ni       (sysRst_n),
    .clear_i      (cks_clear),
    .seed_i       (cks_seed),
    .seed_byte_i  (resp_instr),
    .update_i     (cks_update),
    .update_byte_i(top_byte),
    .sum_o        (cks_sum)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    cks_clear  = 1'b0;
    cks_seed   = 1'b0;
    cks_update = 1'b0;
    accept     = resp_valid & ready_q;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        instr_d  = resp_instr;
        data_d   = resp_data;
        cnt_d    = 4'd0;
        cks_seed = 1'b1;
        state_d  = ST_HEADER;
        // A request landing on the accept edge is served with the new header.
        if (tx_req) begin
          tx_byte_d  = resp_instr;
          tx_valid_d = 1'b1;
          state_d    = ST_DATA;
        end
      end else if (tx_req) begin
        tx_byte_d  = FILL_BYTE;
        tx_valid_d = 1'b1;
        underrun_d = 1'b1;
      end
    end else if (!cs_active) begin
      state_d   = ST_IDLE;
      abort_d   = 1'b1;
      cks_clear = 1'b1;
      data_d    = '0;
      cnt_d     = 4'd0;
    end else if (tx_req) begin
      tx_valid_d = 1'b1;
      if (state_q == ST_HEADER) begin
        tx_byte_d = instr_q;
        state_d   = ST_DATA;
      end else if (state_q == ST_DATA) begin
        tx_byte_d  = top_byte;
        data_d     = data_q << 8;
        cks_update = 1'b1;
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_CSUM;
        end
      end else begin
        tx_byte_d = cks_sum;
        done_d    = 1'b1;
        cks_clear = 1'b1;
        cnt_d     = 4'd0;
        state_d   = ST_IDLE;
      end
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= 8'h00;
      data_q     <= '0;
      cnt_q      <= 4'd0;
      ready_q    <= 1'b0;
      tx_byte_q  <= FILL_BYTE;
      tx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign resp_ready  = ready_q;
  assign tx_byte     = tx_byte_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign underrun    = underrun_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign dbg_state   = state_q;

endmodule
